// File: rtl/axi_mem_resp_pkg.sv
// axi_mem_resp_pkg: shared FSM state encoding and AXI response codes for axi_mem_responder.
package axi_mem_resp_pkg;
    typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_e;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;
endpackage

// File: rtl/axi_mem_resp_ram.sv
// axi_mem_resp_ram: single-port word RAM with byte write enables and a registered,
// read-enabled output so data holds while no read is issued.
module axi_mem_resp_ram #(
    parameter  int DW    = 32,
    parameter  int DEPTH = 1024,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            re,
    input  logic [DW/8-1:0] we,
    input  logic [AW-1:0]   addr,
    input  logic [DW-1:0]   wdata,
    output logic [DW-1:0]   rdata
);
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int b = 0; b < DW/8; b++)
            if (we[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        if (re) rdata <= mem[addr];
    end
endmodule

// File: rtl/axi_mem_responder.sv
// axi_mem_responder: AXI4 slave memory serving one INCR burst at a time with fair AW/AR arbitration.
// Define AXI_MEM_RESP_ERR_EN to return DECERR for beats beyond the array instead of wrapping.
module axi_mem_responder
    import axi_mem_resp_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_WORDS  = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [31:0]             awaddr,
    input  logic [7:0]              awlen,
    input  logic                    wvalid,
    output logic                    wready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    bvalid,
    input  logic                    bready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    input  logic                    arvalid,
    output logic                    arready,
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [31:0]             araddr,
    input  logic [7:0]              arlen,
    output logic                    rvalid,
    input  logic                    rready,
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast
);
    localparam int SW = DATA_WIDTH / 8;
    localparam int BO = $clog2(SW);
    localparam int AW = $clog2(MEM_WORDS);

    state_e                state_q;
    logic [31:0]           addr_q;
    logic [7:0]            len_q;
    logic [8:0]            cnt_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic                  pref_q, bvalid_q, rvalid_q, rlast_q, rzero_q, err_q;
    logic [1:0]            rresp_q;
    logic                  idle, aw_hs, ar_hs, w_hs, issue, oor;
    logic [SW-1:0]         ram_we;
    logic [DATA_WIDTH-1:0] ram_rdata;

`ifdef AXI_MEM_RESP_ERR_EN
    localparam logic [31:0] LIMIT = 32'(MEM_WORDS * SW);
    assign oor = addr_q >= LIMIT;
`else
    logic unused_addr;
    assign oor = 1'b0;
    assign unused_addr = ^addr_q;
`endif

    assign idle    = state_q == IDLE;
    assign awready = idle && awvalid && (!arvalid || pref_q);
    assign arready = idle && arvalid && !awready;
    assign aw_hs   = awvalid && awready;
    assign ar_hs   = arvalid && arready;
    assign wready  = state_q == WDATA;
    assign w_hs    = wvalid && wready;
    // cnt_q counts beats issued; it is 9 bits so a 256-beat burst can run past len_q
    assign issue   = state_q == RDATA && cnt_q <= {1'b0, len_q} && (!rvalid_q || rready);
    assign ram_we  = (w_hs && !oor) ? wstrb : '0;

    assign bvalid = bvalid_q;
    assign bid    = id_q;
    assign bresp  = err_q ? RESP_DECERR : RESP_OKAY;
    assign rvalid = rvalid_q;
    assign rid    = id_q;
    assign rdata  = rzero_q ? '0 : ram_rdata;
    assign rresp  = rresp_q;
    assign rlast  = rlast_q;

    axi_mem_resp_ram #(.DW(DATA_WIDTH), .DEPTH(MEM_WORDS)) u_ram (
        .clk   (clk),
        .re    (issue),
        .we    (ram_we),
        .addr  (addr_q[AW+BO-1:BO]),
        .wdata (wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            id_q     <= '0;
            pref_q   <= 1'b1;
            bvalid_q <= 1'b0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            rzero_q  <= 1'b1;
            err_q    <= 1'b0;
            rresp_q  <= RESP_OKAY;
        end else begin
            case (state_q)
                IDLE: begin
                    if (aw_hs) begin
                        state_q <= WDATA;
                        addr_q  <= awaddr;
                        len_q   <= awlen;
                        cnt_q   <= '0;
                        id_q    <= awid;
                        err_q   <= 1'b0;
                        pref_q  <= 1'b0;
                    end else if (ar_hs) begin
                        state_q <= RDATA;
                        addr_q  <= araddr;
                        len_q   <= arlen;
                        cnt_q   <= '0;
                        id_q    <= arid;
                        pref_q  <= 1'b1;
                    end
                end
                WDATA: begin
                    if (w_hs) begin
                        addr_q <= addr_q + 32'(SW);
                        cnt_q  <= cnt_q + 9'd1;
                        err_q  <= err_q | oor;
                        if (cnt_q[7:0] == len_q) begin
                            state_q  <= WRESP;
                            bvalid_q <= 1'b1;
                        end
                    end
                end
                WRESP: begin
                    if (bready) begin
                        bvalid_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                RDATA: begin
                    if (issue) begin
                        addr_q   <= addr_q + 32'(SW);
                        cnt_q    <= cnt_q + 9'd1;
                        rvalid_q <= 1'b1;
                        rlast_q  <= cnt_q[7:0] == len_q;
                        rzero_q  <= oor;
                        rresp_q  <= oor ? RESP_DECERR : RESP_OKAY;
                    end else if (rvalid_q && rready) begin
                        rvalid_q <= 1'b0;
                        if (rlast_q) begin
                            rlast_q <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_mem_responder.sv
// tb_axi_mem_responder: directed vector table plus hand sequences for bursts, arbitration,
// backpressure, address wrap/decode error and mid-burst reset.
module tb_axi_mem_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, rlast;
    logic [3:0]  awid, bid, arid, rid, wstrb;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [7:0]  awlen, arlen;
    logic [1:0]  bresp, rresp;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] wbuf [0:15];
    logic [31:0] rbuf [0:15];
    logic [1:0]  rrbuf [0:15];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [7];

    always #5 clk = ~clk;

    axi_mem_responder dut (
        .clk(clk), .reset(reset),
        .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arlen(arlen),
        .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic write_burst(input logic [3:0] id, input logic [31:0] a, input int len,
                               input logic [3:0] strb);
        int t;
        logic hs;
        awvalid = 1'b1; awid = id; awaddr = a; awlen = 8'(len);
        t = 0;
        do begin
            @(negedge clk); hs = awready;
            @(posedge clk); #1; t++;
        end while (!hs && t < 50);
        chk("aw_accept", {63'd0, hs}, 64'd1);
        awvalid = 1'b0;
        wvalid = 1'b1; wstrb = strb;
        for (int i = 0; i <= len; i++) begin
            wdata = wbuf[i];
            t = 0;
            do begin
                @(negedge clk); hs = wready;
                @(posedge clk); #1; t++;
            end while (!hs && t < 50);
            if (!hs) chk("w_accept", 64'd0, 64'd1);
        end
        wvalid = 1'b0;
        @(negedge clk);
        chk("bvalid_lat", {63'd0, bvalid}, 64'd1);
        chk("bid", {60'd0, bid}, {60'd0, id});
        chk("bresp", {62'd0, bresp}, 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic read_burst(input logic [3:0] id, input logic [31:0] a, input int len,
                              input logic toggle);
        int t, lat, n;
        logic hs, held, hold_l, first;
        logic [31:0] hold_d;
        rready = 1'b1;
        arvalid = 1'b1; arid = id; araddr = a; arlen = 8'(len);
        t = 0;
        do begin
            @(negedge clk); hs = arready;
            @(posedge clk); #1; t++;
        end while (!hs && t < 50);
        chk("ar_accept", {63'd0, hs}, 64'd1);
        arvalid = 1'b0;
        lat = 1;
        forever begin
            @(negedge clk);
            if (rvalid || lat > 20) break;
            @(posedge clk); #1; lat++;
        end
        chk("rvalid_lat", 64'(lat), 64'd2);
        chk("rid", {60'd0, rid}, {60'd0, id});
        n = 0; t = 0; held = 1'b0; first = 1'b1; hold_d = '0; hold_l = 1'b0;
        while (n <= len && t < 200) begin
            if (!first) @(negedge clk);
            first = 1'b0;
            if (rvalid) begin
                if (held) begin
                    chk("hold_rdata", {32'd0, rdata}, {32'd0, hold_d});
                    chk("hold_rlast", {63'd0, rlast}, {63'd0, hold_l});
                end
                if (rready) begin
                    rbuf[n] = rdata; rrbuf[n] = rresp;
                    chk("rlast", {63'd0, rlast}, {63'd0, n == len});
                    n++; held = 1'b0;
                end else begin
                    held = 1'b1; hold_d = rdata; hold_l = rlast;
                end
            end
            @(posedge clk); #1; t++;
            if (toggle) rready = ~rready;
        end
        if (n <= len) chk("read_timeout", 64'(n), 64'(len + 1));
        rready = 1'b1;
    endtask

    task automatic contend(input logic expect_w);
        awvalid = 1'b1; arvalid = 1'b1; awid = 4'h1; arid = 4'h2;
        awaddr = 32'h200; araddr = 32'h200; awlen = 8'd0; arlen = 8'd0;
        wdata = 32'h5A5A5A5A; wstrb = 4'hF;
        @(negedge clk);
        chk("grant_aw", {63'd0, awready}, {63'd0, expect_w});
        chk("grant_ar", {63'd0, arready}, {63'd0, !expect_w});
        @(posedge clk); #1;
        if (awready === 1'b0 && arready === 1'b0 && expect_w) begin
            awvalid = 1'b0; wvalid = 1'b1;
            @(posedge clk); #1;
            wvalid = 1'b0;
            @(negedge clk);
            chk("contend_b", {63'd0, bvalid}, 64'd1);
            @(posedge clk); #1;
        end else begin
            arvalid = 1'b0;
            @(posedge clk); #1;
            @(negedge clk);
            chk("contend_r", {63'd0, rvalid}, 64'd1);
            @(posedge clk); #1;
        end
        awvalid = 1'b0; arvalid = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
        awid = 0; arid = 0; awaddr = 0; araddr = 0; awlen = 0; arlen = 0; wdata = 0; wstrb = 0;
        vecs[0] = '{32'h20, 32'hAABBCCDD, 4'hF, 32'hAABBCCDD};
        vecs[1] = '{32'h20, 32'h0000EE00, 4'h2, 32'hAABBEEDD};
        vecs[2] = '{32'h24, 32'h01234567, 4'hF, 32'h01234567};
        vecs[3] = '{32'h24, 32'hFFFFFFFF, 4'h9, 32'hFF2345FF};
        vecs[4] = '{32'h24, 32'h00000000, 4'h0, 32'hFF2345FF};
        vecs[5] = '{32'hFFC, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF};
        vecs[6] = '{32'h0, 32'hCAFEF00D, 4'hF, 32'hCAFEF00D};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs", {57'd0, awready, arready, wready, bvalid, rvalid, rlast, 1'b0},
            64'd0);
        chk("rst_regs", {bid, rid, bresp, rresp, rdata}, 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // simultaneous requests: write first, then strict alternation
        contend(1'b1);
        contend(1'b0);
        contend(1'b1);
        contend(1'b0);

        wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33; wbuf[3] = 32'h44;
        write_burst(4'h5, 32'h10, 3, 4'hF);
        read_burst(4'h9, 32'h10, 3, 1'b0);
        for (int i = 0; i < 4; i++) chk("burst_data", {32'd0, rbuf[i]}, {32'd0, wbuf[i]});

        for (int i = 0; i < 7; i++) begin
            wbuf[0] = vecs[i].data;
            write_burst(4'(i), vecs[i].addr, 0, vecs[i].strb);
            read_burst(4'(i + 8), vecs[i].addr, 0, 1'b0);
            chk("vec_data", {32'd0, rbuf[0]}, {32'd0, vecs[i].exp});
        end

        for (int i = 0; i < 8; i++) wbuf[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
        write_burst(4'h3, 32'h100, 7, 4'hF);
        read_burst(4'h4, 32'h100, 7, 1'b1);
        for (int i = 0; i < 8; i++) chk("bp_data", {32'd0, rbuf[i]}, {32'd0, wbuf[i]});

        read_burst(4'h6, 32'hFFC, 1, 1'b0);
        chk("edge_b0", {32'd0, rbuf[0]}, {32'd0, 32'hDEADBEEF});
        chk("edge_r0", {62'd0, rrbuf[0]}, 64'd0);
`ifdef AXI_MEM_RESP_ERR_EN
        chk("edge_b1", {32'd0, rbuf[1]}, 64'd0);
        chk("edge_r1", {62'd0, rrbuf[1]}, 64'd3);
`else
        chk("edge_b1", {32'd0, rbuf[1]}, {32'd0, 32'hCAFEF00D});
        chk("edge_r1", {62'd0, rrbuf[1]}, 64'd0);
`endif

        // reset during beat 2 of a 4-beat write
        awvalid = 1'b1; awid = 4'h7; awaddr = 32'h300; awlen = 8'd3;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b1; wstrb = 4'hF; wdata = 32'h77;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("mid_rst_outs", {57'd0, awready, arready, wready, bvalid, rvalid, rlast, 1'b0},
            64'd0);
        wvalid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_bvalid", {63'd0, bvalid}, 64'd0);
        end
        @(posedge clk); #1;
        wbuf[0] = 32'hA1; wbuf[1] = 32'hB2; wbuf[2] = 32'hC3; wbuf[3] = 32'hD4;
        write_burst(4'h8, 32'h300, 3, 4'hF);
        read_burst(4'h1, 32'h300, 3, 1'b0);
        for (int i = 0; i < 4; i++) chk("post_rst", {32'd0, rbuf[i]}, {32'd0, wbuf[i]});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/axi_mem_responder.md
# axi_mem_responder
AXI4 slave memory model and responder for the VexRiscv/CDMA SoC; it answers read and write bursts issued by the DMA and CPU initiators from an on-chip word array. It services one transaction at a time, arbitrates fairly between the AW and AR channels, and echoes IDs. It sits in simulation and FPGA builds as the CDMA source/destination memory.
## Interface
- DATA_WIDTH, 32, data bus width in bits (multiple of 8); byte address, 32-bit AXI address.
- ID_WIDTH, 4, AXI ID width.
- MEM_WORDS, 1024, array depth in DATA_WIDTH words (power of 2).
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- awvalid  in  1  write address valid.
- awready  out  1  write address ready.
- awid  in  ID_WIDTH  write ID.
- awaddr  in  32  write start byte address (word aligned).
- awlen  in  8  beats minus one.
- wvalid  in  1  write data valid.
- wready  out  1  write data ready.
- wdata  in  DATA_WIDTH  write data.
- wstrb  in  DATA_WIDTH/8  byte enables.
- bvalid  out  1  write response valid.
- bready  in  1  write response ready.
- bid  out  ID_WIDTH  echoed awid.
- bresp  out  2  write response.
- arvalid  in  1  read address valid.
- arready  out  1  read address ready.
- arid  in  ID_WIDTH  read ID.
- araddr  in  32  read start byte address (word aligned).
- arlen  in  8  beats minus one.
- rvalid  out  1  read data valid.
- rready  in  1  read data ready.
- rid  out  ID_WIDTH  echoed arid.
- rdata  out  DATA_WIDTH  read data.
- rresp  out  2  read response.
- rlast  out  1  final read beat.
## Operation
- States IDLE, WDATA, WRESP, RDATA. Size is always full width; every burst is treated as INCR, beat address = start + beat*(DATA_WIDTH/8); word index = address/(DATA_WIDTH/8). No WLAST port: write length comes from awlen.
- IDLE: awready = awvalid && (!arvalid || pref_wr); arready = arvalid && !awready (combinational). AW handshake -> WDATA, latch awid/addr/len; AR handshake -> RDATA. pref_wr set to 0 after a write grant, 1 after a read grant; reset value 1.
- WDATA: wready=1; each W handshake writes enabled bytes only; after awlen+1 beats -> WRESP. WRESP: bvalid=1 until bready, then IDLE.
- RDATA: reads issued while beats remain and (!rvalid || rready); rlast=1 on beat arlen; after rlast handshake -> IDLE.
- Reset (any time, including mid-burst): state IDLE, all valid/ready outputs 0, bid/rid/rdata/bresp/rresp/rlast 0, pref_wr 1; the pending burst is abandoned without response. Memory contents are not reset.
## Timing
- AR handshake at cycle N -> first rvalid at N+2; then one beat per cycle while rready=1; rvalid/rdata/rlast hold stable while rready=0.
- Last W beat at cycle N -> bvalid at N+1.
- B or final R handshake at cycle N -> IDLE at N+1; next AW/AR is accepted at earliest N+1.
- A write to word X followed by a read of X returns the new data (no bypass needed; write completes first).
## Configuration
- AXI_MEM_RESP_ERR_EN defined: a beat whose byte address >= MEM_WORDS*DATA_WIDTH/8 is out of range; such writes are discarded, such reads return 0 with rresp=DECERR (2'b11); bresp=DECERR if any beat of the burst is out of range, else OKAY.
- Undefined: word index wraps modulo MEM_WORDS; bresp/rresp always OKAY (2'b00).
## Structure
- axi_mem_resp_pkg: state enum, RESP_OKAY=2'b00, RESP_DECERR=2'b11.
- Sub-module axi_mem_resp_ram: synchronous single-port RAM with byte write enables, 1-cycle read latency.
## Test plan
- Write awaddr=0x10, awlen=3, data 0x11..0x44, wstrb=0xF -> bvalid one cycle after 4th beat, bresp=0, bid=awid; read back araddr=0x10, arlen=3 -> 0x11,0x22,0x33,0x44, rlast on 4th, first rvalid 2 cycles after AR.
- Write 0xAABBCCDD to 0x20, then wstrb=0x2 data 0x0000EE00 -> read 0x20 returns 0xAABBEEDD.
- awvalid and arvalid high together from reset -> write granted first; repeated contention -> grants alternate W,R,W,R.
- Read arlen=7 with rready toggling 1,0,1,0 -> 8 beats in order, no drops or duplicates, data stable while rready=0.
- With AXI_MEM_RESP_ERR_EN, MEM_WORDS=1024: read araddr=0xFFC, arlen=1 -> beat0 OKAY, beat1 DECERR data 0; without macro, beat1 returns word 0 with OKAY.
- Assert reset during beat 2 of a 4-beat write -> all outputs 0 immediately, bvalid never asserted; next write after reset completes normally.
